conv2d_window_filter: RTL and testbench

- Parametrised KxK 2-D convolution for the streaming video path, with coefficients that can be reprogrammed at run time.
- Input is one column of K vertically aligned pixels per clock, supplied by the upstream line buffers. Output is one saturated 8-bit pixel, plus dv/hs/vs delayed to match the pixel.
- Successor to the fixed 5x5 filter. New behaviour:
  - window advances only on valid data;
  - double-buffered coefficient bank, swapped at frame start;
  - runtime rounding shift;
  - bypass mode.

---
 rtl/conv2d_window_filter.sv | 176 +++++++++++++++++
 tb/tb_conv2d_window_filter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_window_filter.sv
// Streaming KxK convolution with a run-time reprogrammable coefficient bank.
// The shadow bank is copied to the active bank at frame start.
module conv2d_window_filter #(
  parameter int K         = 5,
  parameter int PIX_W     = 8,
  parameter int COEF_W    = 16,
  parameter int DEF_SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [K*PIX_W-1:0]      pixel_data,
  input  logic                    dv_i,
  input  logic                    hs_i,
  input  logic                    vs_i,
  input  logic                    bypass_i,
  input  logic                    coef_we,
  input  logic [5:0]              coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  input  logic [4:0]              shift_data,
  input  logic                    coef_commit,
  output logic                    coef_pending,
  output logic                    dv_o,
  output logic                    hs_o,
  output logic                    vs_o,
  output logic [PIX_W-1:0]        convolved_data
);

  localparam int TAPS  = K * K;
  localparam int LVL   = $clog2(TAPS);
  localparam int NP    = 1 << LVL;
  localparam int LAT   = 3 + LVL;
  localparam int ACC_W = PIX_W + 1 + COEF_W + LVL;
  localparam int RW    = ACC_W + 33;
  localparam int CT    = (K / 2) * K + K / 2;
  localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << DEF_SHIFT);
  localparam logic signed [RW-1:0]     MAXV  = RW'((1 << PIX_W) - 1);

  logic [PIX_W-1:0]         win [K][K];
  logic signed [COEF_W-1:0] shadow_coef [TAPS];
  logic signed [COEF_W-1:0] active_coef [TAPS];
  logic [4:0]               shadow_shift;
  logic [4:0]               active_shift;
  logic                     vs_prev;
  logic                     frame_start;
  logic                     do_copy;

  logic signed [ACC_W-1:0]  prod_c [NP];
  logic signed [ACC_W-1:0]  tree [LVL+1][NP];
  logic                     byp_pipe [LAT-1];
  logic [PIX_W-1:0]         ctr_pipe [LVL+1];
  logic [4:0]               sh_pipe [LVL+1];
  logic [2:0]               ctl_pipe [LAT];

  logic signed [RW-1:0]     sum_ext;
  logic signed [RW-1:0]     rnd;
  logic signed [RW-1:0]     shifted;
  logic [PIX_W-1:0]         sat_pix;
  logic [4:0]               sh;

  // Window advances only on valid columns; column K-1 is the newest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
    end else if (dv_i) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win[r][c] <= win[r][c+1];
        win[r][K-1] <= pixel_data[r*PIX_W +: PIX_W];
      end
    end
  end

  assign frame_start = vs_i & ~vs_prev;
  assign do_copy     = frame_start & (coef_pending | coef_commit);

  // The copy reads the shadow before any same-cycle write lands in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_coef[i] <= (i == CT) ? UNITY : '0;
        active_coef[i] <= (i == CT) ? UNITY : '0;
      end
      shadow_shift <= 5'(DEF_SHIFT);
      active_shift <= 5'(DEF_SHIFT);
      coef_pending <= 1'b0;
      vs_prev      <= 1'b0;
    end else begin
      vs_prev <= vs_i;
      if (coef_we) begin
        for (int i = 0; i < TAPS; i++)
          if (coef_addr == 6'(i))
            shadow_coef[i] <= coef_data;
        shadow_shift <= shift_data;
      end
      if (do_copy) begin
        active_coef  <= shadow_coef;
        active_shift <= shadow_shift;
        coef_pending <= 1'b0;
      end else if (coef_commit) begin
        coef_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NP; i++)
      prod_c[i] = '0;
    for (int i = 0; i < TAPS; i++)
      prod_c[i] = ACC_W'($signed({1'b0, win[i / K][i % K]})) * ACC_W'(active_coef[i]);
  end

  // Level 0 holds the products (zero padded to a power of two), each later level halves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l <= LVL; l++)
        for (int i = 0; i < NP; i++)
          tree[l][i] <= '0;
    end else begin
      for (int i = 0; i < NP; i++)
        tree[0][i] <= prod_c[i];
      for (int l = 1; l <= LVL; l++)
        for (int i = 0; i < (NP >> l); i++)
          tree[l][i] <= tree[l-1][2*i] + tree[l-1][2*i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT - 1; i++) byp_pipe[i] <= 1'b0;
      for (int i = 0; i <= LVL; i++) begin
        ctr_pipe[i] <= '0;
        sh_pipe[i]  <= '0;
      end
      for (int i = 0; i < LAT; i++) ctl_pipe[i] <= '0;
    end else begin
      byp_pipe[0] <= bypass_i;
      for (int i = 1; i < LAT - 1; i++) byp_pipe[i] <= byp_pipe[i-1];
      ctr_pipe[0] <= win[K/2][K/2];
      sh_pipe[0]  <= active_shift;
      for (int i = 1; i <= LVL; i++) begin
        ctr_pipe[i] <= ctr_pipe[i-1];
        sh_pipe[i]  <= sh_pipe[i-1];
      end
      ctl_pipe[0] <= {dv_i, hs_i, vs_i};
      for (int i = 1; i < LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign sh = sh_pipe[LVL];

  always_comb begin
    sum_ext = RW'(tree[LVL][0]);
    rnd     = '0;
    if (sh != 5'd0)
      rnd = RW'(1) << (sh - 5'd1);
    shifted = (sum_ext + rnd) >>> sh;
    if (shifted[RW-1])
      sat_pix = '0;
    else if (shifted > MAXV)
      sat_pix = '1;
    else
      sat_pix = shifted[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      convolved_data <= '0;
    else
      convolved_data <= byp_pipe[LAT-2] ? ctr_pipe[LVL] : sat_pix;
  end

  assign {dv_o, hs_o, vs_o} = ctl_pipe[LAT-1];

endmodule

// File: tb/tb_conv2d_window_filter.sv
// Scoreboard bench for conv2d_window_filter: a window/kernel model predicts each
// valid output pixel, and a monitor pops and compares whenever dv_o is seen.
module tb_conv2d_window_filter;

  localparam int K      = 5;
  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;
  localparam int TAPS   = K * K;
  localparam int LAT    = 3 + $clog2(TAPS);
  localparam int CT     = (K / 2) * K + K / 2;

  logic                clk;
  logic                rst;
  logic [K*PIX_W-1:0]  pixel_data;
  logic                dv_i, hs_i, vs_i, bypass_i;
  logic                coef_we;
  logic [5:0]          coef_addr;
  logic [COEF_W-1:0]   coef_data;
  logic [4:0]          shift_data;
  logic                coef_commit;
  logic                coef_pending;
  logic                dv_o, hs_o, vs_o;
  logic [PIX_W-1:0]    convolved_data;

  conv2d_window_filter #(.K(K), .PIX_W(PIX_W), .COEF_W(COEF_W), .DEF_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .bypass_i(bypass_i), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .shift_data(shift_data), .coef_commit(coef_commit), .coef_pending(coef_pending),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .convolved_data(convolved_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int pix;
    bit hs;
    bit vs;
    int due;
  } exp_t;

  typedef struct {
    logic [K*PIX_W-1:0] col;
    bit dv, hs, vs, byp, we, commit;
    int addr, cdata, sdata;
  } stim_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: window contents, both banks, pending flag, previous vs.
  int win_m [K][K];
  int act [TAPS];
  int shd [TAPS];
  int act_sh, shd_sh;
  bit pend_m, vs_prev_m;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void reset_model();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_m[r][c] = 0;
    for (int i = 0; i < TAPS; i++) begin
      act[i] = (i == CT) ? 256 : 0;
      shd[i] = (i == CT) ? 256 : 0;
    end
    act_sh = 8;
    shd_sh = 8;
    pend_m = 1'b0;
    vs_prev_m = 1'b0;
  endfunction

  function automatic int calc_expected(bit byp);
    longint s, t;
    if (byp) return win_m[K/2][K/2];
    s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        s += longint'(win_m[r][c]) * longint'(act[r*K+c]);
    t = s;
    if (act_sh > 0) t = t + (longint'(1) << (act_sh - 1));
    t = t >>> act_sh;
    if (t < 0) return 0;
    if (t > 255) return 255;
    return int'(t);
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s.col = '0; s.dv = 0; s.hs = 0; s.vs = 0; s.byp = 0; s.we = 0; s.commit = 0;
    s.addr = 0; s.cdata = 0; s.sdata = 0;
    return s;
  endfunction

  function automatic logic [K*PIX_W-1:0] const_col(input int v);
    logic [K*PIX_W-1:0] col;
    for (int r = 0; r < K; r++) col[r*PIX_W +: PIX_W] = PIX_W'(v);
    return col;
  endfunction

  function automatic logic [K*PIX_W-1:0] rand_col();
    logic [K*PIX_W-1:0] col;
    for (int r = 0; r < K; r++) col[r*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, 255));
    return col;
  endfunction

  // Drives one cycle, advances the model, queues the expected pixel, checks pending.
  task automatic applyStimulus(input stim_t s);
    bit fs;
    exp_t e;
    @(negedge clk);
    pixel_data  = s.col;
    dv_i        = s.dv;
    hs_i        = s.hs;
    vs_i        = s.vs;
    bypass_i    = s.byp;
    coef_we     = s.we;
    coef_addr   = 6'(s.addr);
    coef_data   = COEF_W'(s.cdata);
    shift_data  = 5'(s.sdata);
    coef_commit = s.commit;
    if (s.dv)
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_m[r][c] = win_m[r][c+1];
        win_m[r][K-1] = int'(s.col[r*PIX_W +: PIX_W]);
      end
    fs = s.vs && !vs_prev_m;
    if (fs && (pend_m || s.commit)) begin
      act = shd;
      act_sh = shd_sh;
      pend_m = 1'b0;
    end else if (s.commit) begin
      pend_m = 1'b1;
    end
    if (s.we) begin
      if (s.addr < TAPS) shd[s.addr] = s.cdata;
      shd_sh = s.sdata;
    end
    vs_prev_m = s.vs;
    if (s.dv) begin
      e.pix = calc_expected(s.byp);
      e.hs  = s.hs;
      e.vs  = s.vs;
      e.due = cyc + LAT;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput("coef_pending", coef_pending, pend_m);
  endtask

  task automatic stream_const(input int n, input int v);
    stim_t s;
    for (int j = 0; j < n; j++) begin
      s = idle_stim(); s.dv = 1; s.col = const_col(v);
      applyStimulus(s);
    end
  endtask

  task automatic stream_rand(input int n);
    stim_t s;
    for (int j = 0; j < n; j++) begin
      s = idle_stim(); s.dv = 1; s.col = rand_col(); s.hs = ($urandom_range(0, 1) == 1);
      applyStimulus(s);
    end
  endtask

  task automatic stream_distinct(input int n, input int seed);
    stim_t s;
    for (int j = 0; j < n; j++) begin
      s = idle_stim(); s.dv = 1;
      for (int r = 0; r < K; r++) s.col[r*PIX_W +: PIX_W] = PIX_W'((j * 11 + r * 3 + seed) & 255);
      applyStimulus(s);
    end
  endtask

  // Writes every shadow tap while live video keeps streaming.
  task automatic write_kernel(input int tap, input int centre, input int sh);
    stim_t s;
    for (int i = 0; i < TAPS; i++) begin
      s = idle_stim(); s.dv = 1; s.col = rand_col();
      s.we = 1; s.addr = i; s.cdata = (i == CT) ? centre : tap; s.sdata = sh;
      applyStimulus(s);
    end
  endtask

  task automatic frame_start(input bit commit);
    stim_t s;
    s = idle_stim(); s.dv = 1; s.col = rand_col(); s.vs = 1; s.commit = commit;
    applyStimulus(s);
  endtask

  task automatic drive_idle();
    pixel_data = '0; dv_i = 0; hs_i = 0; vs_i = 0; bypass_i = 0;
    coef_we = 0; coef_addr = '0; coef_data = '0; shift_data = '0; coef_commit = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    exp_q.delete();
    reset_model();
    repeat (n) @(posedge clk);
    #1;
    checkOutput("rst_convolved_data", convolved_data, 0);
    checkOutput("rst_dv_o", dv_o, 0);
    checkOutput("rst_hs_o", hs_o, 0);
    checkOutput("rst_vs_o", vs_o, 0);
    checkOutput("rst_coef_pending", coef_pending, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (dv_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_dv_o: got output %0d at cycle %0d, expected no valid output",
                   convolved_data, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pixel", convolved_data, e.pix);
          checkOutput("hs_vs", {hs_o, vs_o}, {e.hs, e.vs});
          checkOutput("latency_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    stim_t s;
    rst = 1'b1;
    drive_idle();
    reset_model();
    do_reset(2);

    stream_distinct(20, 1);

    // Mid-frame commit must wait for the vs rising edge.
    write_kernel(10, 10, 8);
    s = idle_stim(); s.dv = 1; s.col = rand_col(); s.commit = 1;
    applyStimulus(s);
    stream_rand(6);
    frame_start(1'b0);
    stream_const(10, 100);

    // Saturation high and low, each committed in the same cycle as the vs rise.
    write_kernel(256, 256, 8);
    frame_start(1'b1);
    stream_const(10, 200);
    write_kernel(0, -256, 8);
    frame_start(1'b1);
    stream_const(10, 50);

    // dv gap carrying 0xFF must not enter the window.
    stream_distinct(4, 9);
    for (int j = 0; j < 3; j++) begin
      s = idle_stim(); s.col = const_col(255);
      applyStimulus(s);
    end
    stream_distinct(8, 17);

    for (int j = 0; j < 600; j++) begin
      s = idle_stim();
      s.dv     = ($urandom_range(0, 3) != 0);
      s.col    = rand_col();
      s.hs     = ($urandom_range(0, 1) == 1);
      s.vs     = ($urandom_range(0, 49) == 0);
      s.byp    = ($urandom_range(0, 4) == 0);
      s.we     = ($urandom_range(0, 3) == 0);
      s.addr   = $urandom_range(0, 31);
      s.cdata  = int'($urandom_range(0, 4000)) - 2000;
      s.sdata  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(6, 16));
      s.commit = ($urandom_range(0, 29) == 0);
      applyStimulus(s);
    end

    // Reset with a commit pending, then an out-of-range write that must be dropped.
    write_kernel(10, 10, 8);
    s = idle_stim(); s.dv = 1; s.col = rand_col(); s.commit = 1;
    applyStimulus(s);
    stream_rand(3);
    do_reset(2);
    s = idle_stim(); s.we = 1; s.addr = 30; s.cdata = 500; s.sdata = 8;
    applyStimulus(s);
    frame_start(1'b1);
    stream_distinct(15, 5);

    for (int j = 0; j < LAT + 2; j++) applyStimulus(idle_stim());
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
